// File: rtl/fifo_umbral.sv
// fifo_umbral: single-clock FIFO with programmable almost-empty/almost-full thresholds and sticky error
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] umbral_alto,
  input  logic [ADDR_WIDTH-1:0] umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, alto, bajo, alto_n, bajo_n;
  logic [ADDR_WIDTH:0]   count_n;
  logic                  push_ok, pop_ok;
  // flags are registered from next-state count/thresholds so they track count with no lag
  always_comb begin
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    count_n = count + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pop_ok};
    alto_n  = init ? umbral_alto : alto;
    bajo_n  = init ? umbral_bajo : bajo;
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      error        <= 1'b0;
      alto         <= ADDR_WIDTH'(7);
      bajo         <= ADDR_WIDTH'(1);
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + {{(ADDR_WIDTH-1){1'b0}}, push_ok};
      rd_ptr       <= rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, pop_ok};
      count        <= count_n;
      valid_out    <= pop_ok;
      if (pop_ok) data_out <= mem[rd_ptr];
      error        <= error | (push && !push_ok) | (pop && !pop_ok);
      alto         <= alto_n;
      bajo         <= bajo_n;
      empty        <= count_n == '0;
      full         <= count_n == (ADDR_WIDTH+1)'(DEPTH);
      almost_empty <= count_n <= {1'b0, bajo_n};
      almost_full  <= count_n >= {1'b0, alto_n};
    end
  end
endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: directed scenario tests for fifo_umbral with hand-computed expectations
module tb_fifo_umbral;
  logic       clk = 0, reset = 0, init = 0, push = 0, pop = 0;
  logic [2:0] umbral_alto = 0, umbral_bajo = 0;
  logic [5:0] data_in = 0, data_out;
  logic [3:0] count;
  logic       valid_out, empty, full, almost_empty, almost_full, error;
  int         errors = 0, checks = 0;

  fifo_umbral dut (
    .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .error(error)
  );

  always #5 clk = ~clk;

  task automatic do_reset(input int n);
    reset = 1;
    repeat (n) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic cyc(input logic p, input logic [5:0] d, input logic q);
    push = p; data_in = d; pop = q;
    @(posedge clk);
    #1 push = 0; pop = 0;
  endtask

  task automatic load(input logic [2:0] a, input logic [2:0] b);
    init = 1; umbral_alto = a; umbral_bajo = b;
    @(posedge clk);
    #1 init = 0;
  endtask

  task automatic test_reset;
    do_reset(4);
    cyc(0, 0, 0);
    checks++;
    if ({empty, almost_empty, full, almost_full, count, error, valid_out} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: e=%b ae=%b f=%b af=%b cnt=%0d err=%b v=%b, want 1 1 0 0 0 0 0",
               empty, almost_empty, full, almost_full, count, error, valid_out);
    end
  endtask

  task automatic test_fill;
    load(3'd5, 3'd2);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 6'(i), 0);
      checks++;
      if ({count, almost_empty, almost_full, full, error} !== {4'(i), i <= 2, i >= 5, i == 8, 1'b0}) begin
        errors++;
        $display("FAIL fill_%0d: cnt=%0d ae=%b af=%b f=%b err=%b, want %0d %b %b %b 0",
                 i, count, almost_empty, almost_full, full, error, i, i <= 2, i >= 5, i == 8);
      end
    end
  endtask

  task automatic test_overflow_drain;
    cyc(1, 6'h3F, 0);
    checks++;
    if ({error, count, full} !== {1'b1, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL overflow: err=%b cnt=%0d f=%b, want 1 8 1", error, count, full);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1);
      checks++;
      if ({valid_out, data_out, count} !== {1'b1, 6'(i), 4'(8 - i)}) begin
        errors++;
        $display("FAIL drain_%0d: v=%b data=%h cnt=%0d, want 1 %h %0d", i, valid_out, data_out, count, 6'(i), 8 - i);
      end
    end
    cyc(0, 0, 0);
    checks++;
    if ({empty, valid_out, data_out} !== {1'b1, 1'b0, 6'h08}) begin
      errors++;
      $display("FAIL drain_end: e=%b v=%b data=%h, want 1 0 08", empty, valid_out, data_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp;
    do_reset(1);
    for (int i = 0; i < 8; i++) cyc(1, 6'h10 + 6'(i), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 6'h20 + 6'(i), 1);
      checks++;
      if ({count, full, valid_out, data_out, error} !== {4'd8, 1'b1, 1'b1, 6'h10 + 6'(i), 1'b0}) begin
        errors++;
        $display("FAIL full_pushpop_%0d: cnt=%0d f=%b v=%b data=%h err=%b, want 8 1 1 %h 0",
                 i, count, full, valid_out, data_out, error, 6'h10 + 6'(i));
      end
    end
    for (int i = 0; i < 8; i++) begin
      exp = i < 4 ? 6'h14 + 6'(i) : 6'h20 + 6'(i - 4);
      cyc(0, 0, 1);
      checks++;
      if ({valid_out, data_out} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL wrap_order_%0d: v=%b data=%h, want 1 %h", i, valid_out, data_out, exp);
      end
    end
    checks++;
    if ({empty, error} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_end: e=%b err=%b, want 1 0", empty, error);
    end
  endtask

  task automatic test_underflow;
    do_reset(1);
    cyc(0, 0, 1);
    checks++;
    if ({error, valid_out, count, empty} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow: err=%b v=%b cnt=%0d e=%b, want 1 0 0 1", error, valid_out, count, empty);
    end
    do_reset(1);
    cyc(1, 6'h2A, 1);
    checks++;
    if ({error, valid_out, count, empty, almost_empty} !== {1'b1, 1'b0, 4'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL empty_pushpop: err=%b v=%b cnt=%0d e=%b ae=%b, want 1 0 1 0 1",
               error, valid_out, count, empty, almost_empty);
    end
    cyc(0, 0, 1);
    checks++;
    if ({valid_out, data_out, empty} !== {1'b1, 6'h2A, 1'b1}) begin
      errors++;
      $display("FAIL empty_pushpop_read: v=%b data=%h e=%b, want 1 2a 1", valid_out, data_out, empty);
    end
  endtask

  task automatic test_thresholds;
    do_reset(1);
    load(3'd0, 3'd7);
    checks++;
    if ({almost_full, almost_empty} !== 2'b11) begin
      errors++;
      $display("FAIL thr_extreme_idle: af=%b ae=%b, want 1 1", almost_full, almost_empty);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 6'(i), 0);
      checks++;
      if ({almost_full, almost_empty, full} !== {1'b1, i <= 7, i == 8}) begin
        errors++;
        $display("FAIL thr_extreme_%0d: af=%b ae=%b f=%b, want 1 %b %b", i, almost_full, almost_empty, full, i <= 7, i == 8);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    load(3'd3, 3'd5);
    for (int i = 0; i < 4; i++) cyc(1, 6'(i), 0);
    checks++;
    if ({count, almost_full, almost_empty} !== {4'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL mid_prefill: cnt=%0d af=%b ae=%b, want 4 1 1", count, almost_full, almost_empty);
    end
    cyc(0, 0, 1);
    do_reset(1);
    checks++;
    if ({count, empty, error, full, almost_full, almost_empty, valid_out, data_out} !==
        {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h00}) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d e=%b err=%b f=%b af=%b ae=%b v=%b data=%h, want 0 1 0 0 0 1 0 00",
               count, empty, error, full, almost_full, almost_empty, valid_out, data_out);
    end
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 6'(i), 0);
      checks++;
      if ({count, almost_full, almost_empty} !== {4'(i), i == 7, i <= 1}) begin
        errors++;
        $display("FAIL post_reset_%0d: cnt=%0d af=%b ae=%b, want %0d %b %b", i, count, almost_full, almost_empty, i, i == 7, i <= 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow_drain;
    test_back_to_back;
    test_underflow;
    test_thresholds;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
